// File: rtl/i2s_rx.sv
// I2S receiver: brings the asynchronous bck/lrck/i2s_data pins into the mck
// domain, tracks left/right word slots and presents complete stereo frames.
// Words of WIDTH bits are taken MSB first after the one-bit I2S delay slot.
// Extra bits in a slot are ignored. Slots that end early are reported.
module i2s_rx #(
    parameter int WIDTH       = 24,
    parameter int SYNC_STAGES = 2     // legal range 2..3
) (
    input  logic             mck,
    input  logic             rst,
    input  logic             bck,
    input  logic             lrck,
    input  logic             i2s_data,
    output logic [WIDTH-1:0] left_data,
    output logic [WIDTH-1:0] right_data,
    output logic             frame_valid,
    output logic             err_short
);

    // The index counts the delay slot (0), data bits 1..WIDTH and saturates at WIDTH+1.
    localparam int IDX_W = $clog2(WIDTH + 2);
    localparam logic [IDX_W-1:0] IDX_ZERO = '0;
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH);
    localparam logic [IDX_W-1:0] IDX_SAT  = IDX_W'(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] bck_sync_reg;
    logic [SYNC_STAGES-1:0] lrck_sync_reg;
    logic [SYNC_STAGES-1:0] data_sync_reg;
    logic                   bck_dly_reg;
    logic                   lrck_dly_reg;

    logic bck_s;
    logic lrck_s;
    logic data_s;
    logic bck_rise;
    logic lrck_edge;

    state_t state_reg;
    state_t state_next;

    logic [IDX_W-1:0] idx_reg;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;
    logic [WIDTH-1:0] left_hold_reg;
    logic [WIDTH-1:0] right_hold_reg;
    logic             left_ok_reg;
    logic             done_reg;

    logic in_slot;
    logic in_left;
    logic slot_start;
    logic short_word;

    // Synchronizer chains plus one delay flop on bck and lrck for edge detection.
    always_ff @(posedge mck) begin
        if (rst) begin
            bck_sync_reg  <= '0;
            lrck_sync_reg <= '0;
            data_sync_reg <= '0;
            bck_dly_reg   <= 1'b0;
            lrck_dly_reg  <= 1'b0;
        end else begin
            bck_sync_reg  <= {bck_sync_reg[SYNC_STAGES-2:0], bck};
            lrck_sync_reg <= {lrck_sync_reg[SYNC_STAGES-2:0], lrck};
            data_sync_reg <= {data_sync_reg[SYNC_STAGES-2:0], i2s_data};
            bck_dly_reg   <= bck_sync_reg[SYNC_STAGES-1];
            lrck_dly_reg  <= lrck_sync_reg[SYNC_STAGES-1];
        end
    end

    // Data travels through the same number of stages as bck, so it lines up with the rise event.
    assign bck_s      = bck_sync_reg[SYNC_STAGES-1];
    assign lrck_s     = lrck_sync_reg[SYNC_STAGES-1];
    assign data_s     = data_sync_reg[SYNC_STAGES-1];
    assign bck_rise   = bck_s & ~bck_dly_reg;
    assign lrck_edge  = lrck_s ^ lrck_dly_reg;
    assign shift_next = {shift_reg[WIDTH-2:0], data_s};

    // FSM state register.
    always_ff @(posedge mck) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next state: only a falling lrck leaves IDLE, so the first slot is always a left one.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (lrck_edge && !lrck_s) state_next = LEFT;
            LEFT:    if (lrck_edge &&  lrck_s) state_next = RIGHT;
            RIGHT:   if (lrck_edge && !lrck_s) state_next = LEFT;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: slot decode, slot start and short-word detection.
    always_comb begin
        in_slot    = (state_reg != IDLE);
        in_left    = (state_reg == LEFT);
        slot_start = lrck_edge && (in_slot || !lrck_s);
        short_word = lrck_edge && in_slot && (idx_reg != IDX_ZERO) && (idx_reg < IDX_SAT);
    end

    // Bit collection, word hand-off and the registered output pulses.
    always_ff @(posedge mck) begin
        if (rst) begin
            idx_reg        <= '0;
            shift_reg      <= '0;
            left_hold_reg  <= '0;
            right_hold_reg <= '0;
            left_ok_reg    <= 1'b0;
            done_reg       <= 1'b0;
            left_data      <= '0;
            right_data     <= '0;
            frame_valid    <= 1'b0;
            err_short      <= 1'b0;
        end else begin
            done_reg    <= 1'b0;
            frame_valid <= done_reg;
            err_short   <= short_word;

            // Publish the pair one cycle after the right LSB arrives.
            if (done_reg) begin
                left_data   <= left_hold_reg;
                right_data  <= right_hold_reg;
                left_ok_reg <= 1'b0;
            end

            if (slot_start) begin
                // A bck rise landing with the lrck edge is consumed as the delay slot.
                idx_reg   <= bck_rise ? IDX_ONE : IDX_ZERO;
                shift_reg <= '0;
                if (short_word && in_left) begin
                    left_ok_reg <= 1'b0;
                end
            end else if (in_slot && bck_rise) begin
                if (idx_reg == IDX_ZERO) begin
                    idx_reg <= IDX_ONE;
                end else if (idx_reg <= IDX_LAST) begin
                    shift_reg <= shift_next;
                    idx_reg   <= idx_reg + IDX_ONE;
                    if (idx_reg == IDX_LAST) begin
                        if (in_left) begin
                            left_hold_reg <= shift_next;
                            left_ok_reg   <= 1'b1;
                        end else if (left_ok_reg) begin
                            right_hold_reg <= shift_next;
                            done_reg       <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: bck = 16 mck periods, 32-bit slots unless noted.
module tb_i2s_rx;

    localparam int W = 24;

    logic         mck;
    logic         rst;
    logic         bck;
    logic         lrck;
    logic         i2s_data;
    logic [W-1:0] left_data;
    logic [W-1:0] right_data;
    logic         frame_valid;
    logic         err_short;

    int cyc       = 0;
    int fv_cnt    = 0;
    int fv_cyc    = 0;
    int es_cnt    = 0;
    int both_cnt  = 0;
    int rise_cyc  = 0;
    int lsb_cyc   = 0;
    int errors    = 0;
    int checks    = 0;
    int fv_base   = 0;
    int es_base   = 0;

    i2s_rx #(.WIDTH(W), .SYNC_STAGES(2)) dut (
        .mck         (mck),
        .rst         (rst),
        .bck         (bck),
        .lrck        (lrck),
        .i2s_data    (i2s_data),
        .left_data   (left_data),
        .right_data  (right_data),
        .frame_valid (frame_valid),
        .err_short   (err_short)
    );

    initial mck = 1'b0;
    always #5 mck = ~mck;

    always @(posedge mck) cyc <= cyc + 1;

    // Pulse monitor sampled on the falling mck edge.
    always @(negedge mck) begin
        if (frame_valid) begin
            fv_cnt <= fv_cnt + 1;
            fv_cyc <= cyc;
        end
        if (err_short) es_cnt <= es_cnt + 1;
        if (frame_valid && err_short) both_cnt <= both_cnt + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // One bck period, called on a falling mck edge; lrck/data change with falling bck.
    task automatic send_bit(input logic lr, input logic d);
        bck = 1'b0; lrck = lr; i2s_data = d;
        repeat (8) @(negedge mck);
        bck = 1'b1; rise_cyc = cyc;
        repeat (8) @(negedge mck);
    endtask

    task automatic send_slot(input logic lr, input logic [W-1:0] w, input int nbits,
                             input int pad, input logic padv);
        send_bit(lr, padv);
        for (int i = 0; i < nbits; i++) begin
            send_bit(lr, w[W-1-i]);
            if (i == W - 1) lsb_cyc = rise_cyc;
        end
        for (int i = 0; i < pad; i++) send_bit(lr, padv);
    endtask

    task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r, input int lbits,
                              input int pad, input logic padv);
        send_slot(1'b0, l, lbits, pad, padv);
        send_slot(1'b1, r, W, pad, padv);
    endtask

    initial begin
        rst = 1'b1; bck = 1'b0; lrck = 1'b1; i2s_data = 1'b0;
        repeat (4) @(negedge mck);
        #1;
        check("rst_left", 64'(left_data), 64'h0);
        check("rst_right", 64'(right_data), 64'h0);
        check("rst_fv", 64'(frame_valid), 64'h0);
        check("rst_err", 64'(err_short), 64'h0);
        @(negedge mck);
        rst = 1'b0;

        // Released mid right slot: that word must not produce a frame.
        send_slot(1'b1, 24'h123456, W, 7, 1'b0);
        #1;
        check("idle_no_fv", 64'(fv_cnt), 64'd0);
        @(negedge mck);

        // Nominal 64fs frame and latency.
        send_frame(24'h7fffff, 24'h800001, W, 7, 1'b0);
        #1;
        check("f1_fv_cnt", 64'(fv_cnt), 64'd1);
        check("f1_left", 64'(left_data), 64'h7fffff);
        check("f1_right", 64'(right_data), 64'h800001);
        check("f1_latency", 64'(fv_cyc - lsb_cyc), 64'd4);
        check("f1_err", 64'(es_cnt), 64'd0);
        @(negedge mck);

        send_frame(24'h7fffff, 24'h800001, W, 7, 1'b0);
        #1;
        check("f2_fv_cnt", 64'(fv_cnt), 64'd2);
        check("f2_left", 64'(left_data), 64'h7fffff);
        check("f2_right", 64'(right_data), 64'h800001);
        @(negedge mck);

        // Short left word (10 bits): one err_short, frame dropped, outputs hold.
        send_frame(24'h2aaaaa, 24'h155555, 10, 0, 1'b0);
        send_bit(1'b0, 1'b0);
        #1;
        check("short_err", 64'(es_cnt), 64'd1);
        check("short_fv", 64'(fv_cnt), 64'd2);
        check("short_left", 64'(left_data), 64'h7fffff);
        check("short_right", 64'(right_data), 64'h800001);
        @(negedge mck);

        // Reset for one mck cycle mid left word of an ffffff/000000 frame.
        send_slot(1'b0, 24'hffffff, 12, 0, 1'b0);
        rst = 1'b1;
        @(negedge mck);
        rst = 1'b0;
        #1;
        check("mrst_left", 64'(left_data), 64'h0);
        check("mrst_right", 64'(right_data), 64'h0);
        check("mrst_fv", 64'(frame_valid), 64'h0);
        check("mrst_err", 64'(err_short), 64'h0);
        fv_base = fv_cnt; es_base = es_cnt;
        @(negedge mck);
        for (int i = 0; i < 19; i++) send_bit(1'b0, 1'b1);
        send_slot(1'b1, 24'h000000, W, 7, 1'b0);
        #1;
        check("mrst_abort_fv", 64'(fv_cnt - fv_base), 64'd0);
        check("mrst_abort_err", 64'(es_cnt - es_base), 64'd0);
        @(negedge mck);
        send_frame(24'hffffff, 24'h000000, W, 7, 1'b0);
        #1;
        check("mrst_next_fv", 64'(fv_cnt - fv_base), 64'd1);
        check("mrst_next_left", 64'(left_data), 64'hffffff);
        check("mrst_next_right", 64'(right_data), 64'h000000);
        @(negedge mck);

        // Long slots with trailing junk ones.
        es_base = es_cnt;
        send_frame(24'ha5a5a5, 24'h5a5a5a, W, 8, 1'b1);
        #1;
        check("junk_fv", 64'(fv_cnt - fv_base), 64'd2);
        check("junk_left", 64'(left_data), 64'ha5a5a5);
        check("junk_right", 64'(right_data), 64'h5a5a5a);
        check("junk_err", 64'(es_cnt - es_base), 64'd0);
        @(negedge mck);

        // lrck falls in the same mck sample as a bck rise: that bit is the delay slot.
        bck = 1'b0; i2s_data = 1'b0;
        repeat (8) @(negedge mck);
        bck = 1'b1; lrck = 1'b0; i2s_data = 1'b1;
        repeat (8) @(negedge mck);
        for (int i = 0; i < W; i++) send_bit(1'b0, logic'((24'h3c3c3c >> (W - 1 - i)) & 1));
        for (int i = 0; i < 7; i++) send_bit(1'b0, 1'b0);
        send_slot(1'b1, 24'hc3c3c3, W, 7, 1'b0);
        #1;
        check("coin_fv", 64'(fv_cnt - fv_base), 64'd3);
        check("coin_left", 64'(left_data), 64'h3c3c3c);
        check("coin_right", 64'(right_data), 64'hc3c3c3);
        check("coin_err", 64'(es_cnt - es_base), 64'd0);
        check("fv_err_overlap", 64'(both_cnt), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
